// File: rtl/lenet_pkg.sv
// Constants and types shared by the image loader and the LeNet accelerator top.
// The image geometry and pixel width must stay identical on both sides of the interface.
package lenet_pkg;
    localparam int TOP_BITWIDTH = 9;
    localparam int IMG_DIM      = 28;
    localparam int IMG_PIXELS   = IMG_DIM * IMG_DIM;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } loader_state_t;

    typedef logic signed [TOP_BITWIDTH-1:0] pixel_t;
endpackage

// File: rtl/image_stream_loader_raster_counter.sv
// Row-major raster position counter: column advances first, then row.
// Flags the final position of the raster and supports a synchronous clear.
module raster_counter #(
    parameter int DIM = 28,
    parameter int W   = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_advance,
    output logic [W-1:0] o_row,
    output logic [W-1:0] o_col,
    output logic         o_last
);
    localparam logic [W-1:0] MAX_POS = W'(DIM - 1);

    logic [W-1:0] r_row;
    logic [W-1:0] r_col;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (r_col == MAX_POS) begin
                r_col <= '0;
                r_row <= (r_row == MAX_POS) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == MAX_POS) && (r_col == MAX_POS);
endmodule

// File: rtl/image_stream_loader.sv
// Assembles a serial signed pixel stream into a full image and holds it until acknowledged.
// Frames whose s_last does not land on the final raster position are dropped with an error pulse.
module image_stream_loader #(
    parameter int top_bitwidth = lenet_pkg::TOP_BITWIDTH,
    parameter int IMG_DIM      = lenet_pkg::IMG_DIM
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic signed [top_bitwidth-1:0]                         s_pixel,
    input  logic                                                   s_valid,
    input  logic                                                   s_last,
    output logic                                                   s_ready,
    output logic signed [IMG_DIM-1:0][IMG_DIM-1:0][top_bitwidth-1:0] image,
    output logic                                                   image_valid,
    input  logic                                                   image_ack,
    output logic                                                   frame_error,
    output logic [7:0]                                             frame_count
);
    import lenet_pkg::*;

    localparam int POS_W = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;

    loader_state_t      r_state;
    loader_state_t      w_state_next;
    logic [POS_W-1:0]   w_row;
    logic [POS_W-1:0]   w_col;
    logic               w_last_pos;
    logic               w_accept;
    logic               w_write;
    logic               w_clear;
    logic               w_advance;
    logic               w_error_next;
    logic               w_count_inc;
    logic               r_frame_error;
    logic [7:0]         r_frame_count;

    // Readiness depends on state only, so the source never sees a combinational loop.
    assign s_ready     = !reset && (r_state != HOLD);
    assign w_accept    = s_valid && s_ready;
    assign image_valid = (r_state == HOLD);
    assign frame_error = r_frame_error;
    assign frame_count = r_frame_count;

    raster_counter #(
        .DIM (IMG_DIM),
        .W   (POS_W)
    ) u_raster (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last_pos)
    );

    always_comb begin
        w_state_next = r_state;
        w_write      = 1'b0;
        w_clear      = 1'b0;
        w_advance    = 1'b0;
        w_error_next = 1'b0;
        w_count_inc  = 1'b0;
        case (r_state)
            LOAD: begin
                if (w_accept) begin
                    if (!w_last_pos) begin
                        if (s_last) begin
                            w_clear      = 1'b1;
                            w_error_next = 1'b1;
                        end else begin
                            w_write   = 1'b1;
                            w_advance = 1'b1;
                        end
                    end else begin
                        w_write = 1'b1;
                        w_clear = 1'b1;
                        if (s_last) begin
                            w_state_next = HOLD;
                            w_count_inc  = 1'b1;
                        end else begin
                            w_state_next = DRAIN;
                            w_error_next = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (w_accept && s_last) begin
                    w_state_next = LOAD;
                end
            end
            HOLD: begin
                if (image_ack) begin
                    w_state_next = LOAD;
                end
            end
            default: begin
                w_state_next = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= LOAD;
            r_frame_error <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_state       <= w_state_next;
            r_frame_error <= w_error_next;
            if (w_count_inc) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    // One register row per image row; each row only decodes its own write enable.
    genvar gi;
    generate
        for (gi = 0; gi < IMG_DIM; gi++) begin : g_row
            logic [IMG_DIM-1:0][top_bitwidth-1:0] r_row_data;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_row_data <= '0;
                end else if (w_write && (w_row == POS_W'(gi))) begin
                    r_row_data[w_col] <= s_pixel;
                end
            end

            assign image[gi] = r_row_data;
        end
    endgenerate
endmodule

// File: tb/tb_image_stream_loader.sv
// Directed bench for image_stream_loader: stimulus pushes expected frames and error pulses
// into queues, and a separate monitor pops and compares whenever the DUT presents them.
module tb_image_stream_loader;
    import lenet_pkg::*;

    logic                                   clk = 1'b0;
    logic                                   reset;
    logic signed [8:0]                      s_pixel;
    logic                                   s_valid;
    logic                                   s_last;
    logic                                   s_ready;
    logic signed [27:0][27:0][8:0]          image;
    logic                                   image_valid;
    logic                                   image_ack;
    logic                                   frame_error;
    logic [7:0]                             frame_count;

    int     checks = 0;
    int     errors = 0;
    int     exp_cnt = 0;
    time    t_hs = 0;
    bit     prev_valid = 1'b0;

    pixel_t exp_pix_q[$];
    int     exp_cnt_q[$];
    time    exp_t_q[$];
    time    err_q[$];

    image_stream_loader dut (
        .clk         (clk),
        .reset       (reset),
        .s_pixel     (s_pixel),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .image       (image),
        .image_valid (image_valid),
        .image_ack   (image_ack),
        .frame_error (frame_error),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic pixel_t px_val(input int k, input int seed);
        int v;
        if (seed == 0) v = (k % 256) - 128;
        else           v = ((k * 7 + seed) % 512) - 256;
        return pixel_t'(v);
    endfunction

    function automatic int img_at(input int r, input int c);
        pixel_t a;
        a = image[r][c];
        return int'(a);
    endfunction

    function automatic int nonzero_count();
        int n = 0;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                if (image[r][c] != 9'd0) n++;
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered and left just after a rising edge; t_hs records the accepting edge.
    task automatic send_px(input pixel_t p, input logic last, input bit throttle);
        int  tries = 0;
        bit  done  = 1'b0;
        while (!done) begin
            if (throttle && ($urandom_range(0, 1) == 0)) begin
                s_valid = 1'b0;
                s_last  = 1'b1;
                s_pixel = 9'($urandom_range(0, 511));
                step();
            end else begin
                s_valid = 1'b1;
                s_pixel = p;
                s_last  = last;
                @(negedge clk);
                done = s_ready;
                @(posedge clk);
                t_hs = $time;
                #1;
            end
            tries++;
            if (!done && tries > 400) begin
                check("send_px_timeout", 0, 1);
                done = 1'b1;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int seed, input bit throttle);
        for (int k = 0; k < 784; k++) send_px(px_val(k, seed), (k == 783), throttle);
        exp_cnt = (exp_cnt + 1) % 256;
        for (int k = 0; k < 784; k++) exp_pix_q.push_back(px_val(k, seed));
        exp_cnt_q.push_back(exp_cnt);
        exp_t_q.push_back(t_hs);
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!image_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("image_valid_rise", int'(image_valid), 1);
        step();
    endtask

    task automatic ack_image();
        image_ack = 1'b1;
        step();
        image_ack = 1'b0;
        @(negedge clk);
        check("ack_valid_low", int'(image_valid), 0);
        check("ack_ready_high", int'(s_ready), 1);
        step();
    endtask

    task automatic expect_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, int'(image_valid), 0);
        check({tag, "_count"}, int'(frame_count), 0);
        check({tag, "_nonzero"}, nonzero_count(), 0);
        step();
    endtask

    // Monitor: every frame_error pulse and every image_valid rise consumes one expectation.
    always @(negedge clk) begin
        if (frame_error) begin
            checks++;
            if (err_q.size() == 0) begin
                errors++;
                $display("FAIL frame_error: unexpected pulse at t=%0t, required none", $time);
            end else begin
                time te;
                te = err_q.pop_front();
                $display("frame_error pulse at t=%0t", $time);
                if ($time != te + 5) begin
                    errors++;
                    $display("FAIL frame_error_time: got t=%0t, required t=%0t", $time, te + 5);
                end
            end
        end
        if (image_valid && !prev_valid) begin
            if (exp_cnt_q.size() == 0) begin
                check("unexpected_image_valid", 1, 0);
            end else begin
                int mism = 0;
                int fr = 0, fc = 0, fa = 0, fe = 0;
                time tl;
                for (int r = 0; r < 28; r++)
                    for (int c = 0; c < 28; c++) begin
                        pixel_t e;
                        e = exp_pix_q.pop_front();
                        if (img_at(r, c) != int'(e)) begin
                            if (mism == 0) begin fr = r; fc = c; fa = img_at(r, c); fe = int'(e); end
                            mism++;
                        end
                    end
                checks++;
                if (mism != 0) begin
                    errors++;
                    $display("FAIL image: %0d pixels differ, first [%0d][%0d] got %0d required %0d",
                             mism, fr, fc, fa, fe);
                end
                check("frame_count", int'(frame_count), exp_cnt_q.pop_front());
                tl = exp_t_q.pop_front();
                check("valid_latency", int'($time - tl), 5);
                $display("frame delivered: count=%0d t=%0t", frame_count, $time);
            end
        end
        prev_valid = image_valid;
    end

    initial begin
        int bad;
        reset     = 1'b1;
        s_valid   = 1'b0;
        s_pixel   = '0;
        s_last    = 1'b0;
        image_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", int'(s_ready), 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_error", int'(frame_error), 0);
        check("rst_ready", int'(s_ready), 1);
        step();
        expect_reset_state("rst");

        // Nominal frame with hand-computed corner values.
        send_frame(0, 1'b0);
        wait_valid();
        check("img00", img_at(0, 0), -128);
        check("img0_27", img_at(0, 27), -101);
        check("img27_27", img_at(27, 27), -113);
        check("count_after_1", int'(frame_count), 1);

        // Source keeps offering a pixel while the image is held.
        bad = 0;
        s_valid = 1'b1;
        s_pixel = 9'sd77;
        s_last  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_ready || !image_valid) bad++;
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("hold_ready_low", bad, 0);
        check("hold_img0_27", img_at(0, 27), -101);
        check("hold_img27_27", img_at(27, 27), -113);
        ack_image();

        send_frame(3, 1'b0);
        wait_valid();
        ack_image();

        // Short frame: s_last on pixel 99.
        for (int k = 0; k < 100; k++) send_px(px_val(k, 11), (k == 99), 1'b0);
        err_q.push_back(t_hs);
        repeat (3) step();
        check("short_no_valid", int'(image_valid), 0);
        send_frame(5, 1'b0);
        wait_valid();
        check("after_short_img00", img_at(0, 0), int'(px_val(0, 5)));
        ack_image();

        // Long frame: 784 pixels without s_last, then 10 more ending with s_last.
        for (int k = 0; k < 784; k++) begin
            send_px(px_val(k, 13), 1'b0, 1'b0);
            if (k == 783) err_q.push_back(t_hs);
        end
        for (int k = 0; k < 10; k++) send_px(px_val(k, 17), (k == 9), 1'b0);
        repeat (3) step();
        check("long_no_valid", int'(image_valid), 0);
        send_frame(19, 1'b0);
        wait_valid();
        ack_image();

        // Throttled source with garbage on idle cycles.
        send_frame(23, 1'b1);
        wait_valid();
        check("count_after_throttle", int'(frame_count), 5);
        ack_image();

        // Reset partway through a frame.
        for (int k = 0; k < 400; k++) send_px(px_val(k, 29), 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_ready", int'(s_ready), 0);
        step();
        reset = 1'b0;
        exp_cnt = 0;
        expect_reset_state("midrst");

        send_frame(31, 1'b0);
        wait_valid();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_cnt = 0;
        expect_reset_state("holdrst");

        send_frame(37, 1'b0);
        wait_valid();
        check("count_after_resets", int'(frame_count), 1);
        ack_image();

        repeat (5) step();
        check("queues_empty", exp_cnt_q.size() + err_q.size() + exp_pix_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
